// File: rtl/axi_buffer_rab_bram_arb.sv
// axi_buffer_rab_bram_arb: round-robin share of one RAB FIFO upstream port with flush sequencing; RAB_ARB_BURST_LOCK_EN adds burst locking
module axi_buffer_rab_bram_arb #(
  parameter int NUM_IN     = 4,
  parameter int LOG_NUM_IN = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_IN-1:0]              in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]              in_last,
  output logic [NUM_IN-1:0]              in_ready,
  output logic                           buf_valid,
  output logic [DATA_WIDTH-1:0]          buf_data,
  input  logic                           buf_ready,
  output logic                           buf_flush,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic [LOG_NUM_IN-1:0]          grant_id,
  output logic                           busy
);
  typedef enum logic [1:0] {ARB, LOCK, FLUSH, DONE} state_t;
  state_t                r_state;
  logic [LOG_NUM_IN-1:0] r_last_grant, r_lock_id, w_scan, w_sel;
  logic                  w_open, w_xfer;
  // round-robin scan: lowest offset after last_grant wins, falls back to last_grant
  always_comb begin
    w_scan = r_last_grant;
    for (int k = NUM_IN; k >= 1; k--)
      if (in_valid[(int'(r_last_grant) + k) % NUM_IN]) w_scan = LOG_NUM_IN'((int'(r_last_grant) + k) % NUM_IN);
  end
  assign w_sel      = (r_state == LOCK) ? r_lock_id : w_scan;
  assign w_open     = rstn && !flush_req && (r_state == ARB || r_state == LOCK);
  assign buf_valid  = w_open && in_valid[w_sel];
  assign buf_data   = rstn ? in_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign in_ready   = (w_open && buf_ready) ? NUM_IN'(1) << w_sel : '0;
  assign grant_id   = rstn ? w_sel : '0;
  assign buf_flush  = rstn && r_state == FLUSH;
  assign flush_done = rstn && r_state == DONE;
  assign w_xfer     = buf_valid && buf_ready;
`ifdef RAB_ARB_BURST_LOCK_EN
  assign busy = rstn && r_state == LOCK;
`else
  logic w_unused;
  assign w_unused = ^in_last;
  assign busy     = 1'b0;
`endif
  // arbitration state, grant history and flush sequencing
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ARB;
      r_last_grant <= LOG_NUM_IN'(NUM_IN-1);
      r_lock_id    <= '0;
    end else begin
      case (r_state)
        ARB, LOCK: begin
          if (flush_req) r_state <= FLUSH;
          else if (w_xfer) begin
            r_last_grant <= w_sel;
`ifdef RAB_ARB_BURST_LOCK_EN
            if (r_state == ARB && !in_last[w_sel]) begin
              r_state   <= LOCK;
              r_lock_id <= w_sel;
            end else if (r_state == LOCK && in_last[w_sel]) r_state <= ARB;
`endif
          end
        end
        FLUSH: begin
          r_state      <= DONE;
          r_last_grant <= LOG_NUM_IN'(NUM_IN-1);
        end
        default: r_state <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_buffer_rab_bram_arb.sv
// tb_axi_buffer_rab_bram_arb: directed plus random stimulus against a behavioural arbiter model
module tb_axi_buffer_rab_bram_arb;
  localparam int N = 4, LN = 2, DW = 32;
  logic clk = 0, rstn = 0, buf_ready = 1, flush_req = 0;
  logic [N-1:0] in_valid = '0, in_last = '1, in_ready;
  logic [N*DW-1:0] in_data;
  logic buf_valid, buf_flush, flush_done, busy;
  logic [DW-1:0] buf_data;
  logic [LN-1:0] grant_id, g_seen;
  int n_checks = 0, n_errors = 0;
  int seq[N], hs[N];
  int m_state = 0, m_last = N-1, m_lock = 0;
  axi_buffer_rab_bram_arb #(.NUM_IN(N), .LOG_NUM_IN(LN), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .buf_valid(buf_valid), .buf_data(buf_data), .buf_ready(buf_ready),
    .buf_flush(buf_flush), .flush_req(flush_req), .flush_done(flush_done),
    .grant_id(grant_id), .busy(busy));
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) in_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle();
    int sel;
    logic open, ev, xfer;
    logic [N-1:0] er;
    open = rstn && !flush_req && m_state < 2;
    sel = m_last;
    if (m_state == 1) sel = m_lock;
    else for (int k = 1; k <= N; k++) if (in_valid[(m_last+k)%N]) begin sel = (m_last+k)%N; break; end
    ev = open && in_valid[sel];
    er = (open && buf_ready) ? N'(1) << sel : '0;
    xfer = ev && buf_ready;
    @(negedge clk);
    g_seen = grant_id;
    for (int i = 0; i < N; i++) hs[i] += int'(in_valid[i] && in_ready[i]);
    check("buf_valid", buf_valid, ev);
    check("in_ready", in_ready, er);
    check("buf_flush", buf_flush, rstn && m_state == 2);
    check("flush_done", flush_done, rstn && m_state == 3);
    check("busy", busy, rstn && m_state == 1);
    if (ev || !rstn) begin
      check("grant_id", grant_id, rstn ? sel : 0);
      check("buf_data", buf_data, rstn ? {8'(sel), 24'(seq[sel])} : 32'd0);
    end
    @(posedge clk);
    if (xfer) seq[sel]++;
    if (!rstn) begin
      m_state = 0; m_last = N-1; m_lock = 0;
    end else case (m_state)
      0, 1: if (flush_req) m_state = 2;
            else if (xfer) begin
              m_last = sel;
`ifdef RAB_ARB_BURST_LOCK_EN
              if (m_state == 0 && !in_last[sel]) begin m_state = 1; m_lock = sel; end
              else if (m_state == 1 && in_last[sel]) m_state = 0;
`endif
            end
      2: begin m_state = 3; m_last = N-1; end
      default: m_state = 0;
    endcase
    #1;
  endtask
  initial begin
    int base;
    for (int i = 0; i < N; i++) begin seq[i] = 0; hs[i] = 0; end
    in_valid = '1;
    repeat (3) cycle();
    rstn = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_seq", g_seen, i % N);
    end
    in_valid = 4'b0100;
    buf_ready = 0;
    base = hs[2];
    repeat (5) cycle();
    check("stall_hold", hs[2], base);
    buf_ready = 1;
    cycle();
    check("stall_xfer", hs[2], base + 1);
    in_valid = 4'b0111;
    base = hs[1];
    repeat (8) begin
      in_last = {2'b11, (hs[1] - base) == 2, 1'b1};
      cycle();
    end
    in_last = '1;
    in_valid = '1;
    repeat (2) cycle();
    flush_req = 1;
    cycle();
    flush_req = 0;
    repeat (2) cycle();
    cycle();
    check("flush_prio", g_seen, 0);
    in_last = 4'b1101;
    repeat (3) cycle();
    rstn = 0;
    cycle();
    rstn = 1;
    cycle();
    check("reset_prio", g_seen, 0);
    repeat (3000) begin
      in_valid = N'($urandom);
      in_last = N'($urandom | $urandom);
      buf_ready = $urandom_range(3) != 0;
      flush_req = $urandom_range(40) == 0;
      rstn = $urandom_range(150) != 0;
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
